// File: rtl/piso_frame_tx_pkg.sv
// Shared types and helpers for the framed serial transmitter and its companions.
// Imported by the frame FSM and the bit timer.
package piso_frame_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Ceiling log2, usable in parameter and localparam expressions.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/piso_frame_tx_bit_timer.sv
// Down-counter pacing one serial bit period: synchronous clear reloads it, and
// o_tick marks the last cycle of each period while enabled.
module piso_frame_tx_bit_timer
  import piso_frame_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned CNT_W        = clog2(CLKS_PER_BIT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tick
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, regardless of block ordering in simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= RELOAD;
    end else if (i_en) begin
      r_count <= (r_count == '0) ? RELOAD : r_count - 1'b1;
    end
  end

  // Tick deliberately ignores i_clear: the owner derives clear from the tick.
  assign o_tick = i_en && (r_count == '0);

endmodule

// File: rtl/piso_frame_tx.sv
// Framed parallel-in/serial-out transmitter: start bit, WIDTH data bits LSB
// first, stop bit, each held CLKS_PER_BIT cycles on an idle-high line.
module piso_frame_tx
  import piso_frame_tx_pkg::*;
#(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IDX_W = clog2(WIDTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_e           r_state, w_state_next;
  logic [WIDTH-1:0] r_shift, w_shift_next;
  logic [IDX_W-1:0] r_idx, w_idx_next;
  logic             r_ser, w_ser_next;
  logic             r_done, w_done_next;
  logic             w_tick;
  logic             w_timer_clear;
  logic             w_accept;

  assign load_ready = (r_state == ST_IDLE);
  assign w_accept   = load_valid && load_ready;
  assign busy       = (r_state != ST_IDLE);
  assign ser_out    = r_ser;
  assign done       = r_done;

  piso_frame_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clear(w_timer_clear),
    .i_en   (busy),
    .o_tick (w_tick)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_idx_next   = r_idx;
    w_done_next  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_shift_next = load_data;
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        if (w_tick) w_state_next = ST_DATA;
      end
      ST_DATA: begin
        if (w_tick) begin
          w_shift_next = r_shift >> 1;
          if (r_idx == LAST_IDX) w_state_next = ST_STOP;
          else                   w_idx_next   = r_idx + 1'b1;
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          w_state_next = ST_IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    w_timer_clear = (w_state_next != r_state);
    if (w_timer_clear) w_idx_next = '0;

    // The line level is registered, so it is chosen from the upcoming state.
    unique case (w_state_next)
      ST_START: w_ser_next = START_BIT;
      ST_DATA:  w_ser_next = w_shift_next[0];
      ST_STOP:  w_ser_next = STOP_BIT;
      default:  w_ser_next = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_ser   <= IDLE_LEVEL;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_shift <= w_shift_next;
      r_idx   <= w_idx_next;
      r_ser   <= w_ser_next;
      r_done  <= w_done_next;
    end
  end

endmodule

// File: tb/tb_piso_frame_tx.sv
// Directed bench for piso_frame_tx: four instances cover the default timing,
// one-cycle bits, a one-bit word and a sixteen-bit word.
module tb_piso_frame_tx;

  localparam int N_DUT = 4;
  localparam int W0 = 4,  C0 = 4;
  localparam int W1 = 4,  C1 = 1;
  localparam int W2 = 1,  C2 = 3;
  localparam int W3 = 16, C3 = 2;

  logic        clk;
  logic        rst_n;
  logic        valid [N_DUT];
  logic [15:0] data  [N_DUT];
  logic        ready [N_DUT];
  logic        ser   [N_DUT];
  logic        busy  [N_DUT];
  logic        done  [N_DUT];

  int n_checks;
  int n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  piso_frame_tx #(.WIDTH(W0), .CLKS_PER_BIT(C0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .load_valid(valid[0]), .load_ready(ready[0]),
    .load_data(data[0][W0-1:0]), .ser_out(ser[0]), .busy(busy[0]), .done(done[0]));
  piso_frame_tx #(.WIDTH(W1), .CLKS_PER_BIT(C1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .load_valid(valid[1]), .load_ready(ready[1]),
    .load_data(data[1][W1-1:0]), .ser_out(ser[1]), .busy(busy[1]), .done(done[1]));
  piso_frame_tx #(.WIDTH(W2), .CLKS_PER_BIT(C2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .load_valid(valid[2]), .load_ready(ready[2]),
    .load_data(data[2][W2-1:0]), .ser_out(ser[2]), .busy(busy[2]), .done(done[2]));
  piso_frame_tx #(.WIDTH(W3), .CLKS_PER_BIT(C3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .load_valid(valid[3]), .load_ready(ready[3]),
    .load_data(data[3][W3-1:0]), .ser_out(ser[3]), .busy(busy[3]), .done(done[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int wid(input int k);
    case (k)
      0: return W0;
      1: return W1;
      2: return W2;
      default: return W3;
    endcase
  endfunction

  function automatic int cpb(input int k);
    case (k)
      0: return C0;
      1: return C1;
      2: return C2;
      default: return C3;
    endcase
  endfunction

  // Called at a negedge with instance k idle; returns at the negedge of frame cycle 1.
  task automatic launch(input int k, input logic [15:0] word, input bit hold);
    check($sformatf("ready_before_load d%0d", k), ready[k], 1);
    valid[k] = 1'b1;
    data[k]  = word;
    @(posedge clk);
    @(negedge clk);
    if (!hold) valid[k] = 1'b0;
  endtask

  // Walks the whole frame from cycle 1, ends at the negedge of the done cycle.
  task automatic expect_frame(input int k, input logic [15:0] word);
    int w, c, n, bp, lows, exp_lows;
    logic        e;
    logic [15:0] rx;
    w = wid(k);
    c = cpb(k);
    n = (w + 2) * c;
    lows = 0;
    rx = '0;
    exp_lows = c;
    for (int b = 0; b < w; b++) if (!word[b]) exp_lows += c;
    for (int cyc = 1; cyc <= n; cyc++) begin
      bp = (cyc - 1) / c;
      if (bp == 0)      e = 1'b0;
      else if (bp <= w) e = word[bp-1];
      else              e = 1'b1;
      check($sformatf("ser d%0d word %0h cyc %0d", k, word, cyc), ser[k], e);
      check($sformatf("busy d%0d cyc %0d", k, cyc), busy[k], 1);
      check($sformatf("ready d%0d cyc %0d", k, cyc), ready[k], 0);
      check($sformatf("early_done d%0d cyc %0d", k, cyc), done[k], 0);
      if (!ser[k]) lows++;
      if (bp >= 1 && bp <= w && ((cyc - 1) % c) == c / 2) rx[bp-1] = ser[k];
      @(negedge clk);
    end
    check($sformatf("low_cycles d%0d", k), lows, exp_lows);
    check($sformatf("decoded d%0d", k), rx, word);
    check($sformatf("done_pulse d%0d", k), done[k], 1);
    check($sformatf("busy_after d%0d", k), busy[k], 0);
    check($sformatf("ready_on_done d%0d", k), ready[k], 1);
    check($sformatf("ser_idle d%0d", k), ser[k], 1);
  endtask

  task automatic expect_quiet(input int k);
    @(negedge clk);
    check($sformatf("done_cleared d%0d", k), done[k], 0);
    check($sformatf("ser_idle_after d%0d", k), ser[k], 1);
  endtask

  initial begin
    logic [15:0] word;
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < N_DUT; i++) begin
      valid[i] = 1'b0;
      data[i]  = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < N_DUT; i++) begin
      check($sformatf("rst_ser d%0d", i), ser[i], 1);
      check($sformatf("rst_busy d%0d", i), busy[i], 0);
      check($sformatf("rst_ready d%0d", i), ready[i], 1);
      check($sformatf("rst_done d%0d", i), done[i], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Single frame: 0,1,1,0,1,1 at four cycles each.
    launch(0, 16'hB, 1'b0);
    expect_frame(0, 16'hB);
    expect_quiet(0);

    // Stall: 1110 presented while busy is only taken on the done cycle.
    launch(0, 16'h1, 1'b1);
    data[0] = 16'hE;
    expect_frame(0, 16'h1);
    @(posedge clk);
    @(negedge clk);
    valid[0] = 1'b0;
    expect_frame(0, 16'hE);
    expect_quiet(0);

    // One cycle per bit.
    launch(1, 16'h6, 1'b0);
    expect_frame(1, 16'h6);
    expect_quiet(1);

    // All-zero and all-one words.
    launch(0, 16'h0, 1'b0);
    expect_frame(0, 16'h0);
    expect_quiet(0);
    launch(0, 16'hF, 1'b0);
    expect_frame(0, 16'hF);
    expect_quiet(0);

    // Width sweep with random words.
    for (int r = 0; r < 3; r++) begin
      word = 16'($urandom_range(0, 1));
      launch(2, word, 1'b0);
      expect_frame(2, word);
      expect_quiet(2);
      word = 16'($urandom_range(0, 65535));
      launch(3, word, 1'b0);
      expect_frame(3, word);
      expect_quiet(3);
    end

    // Reset in the middle of the first data bit (a zero) of 1010.
    launch(0, 16'hA, 1'b0);
    repeat (5) @(negedge clk);
    check("pre_reset_ser", ser[0], 0);
    check("pre_reset_busy", busy[0], 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_ser", ser[0], 1);
    check("async_rst_busy", busy[0], 0);
    check("async_rst_ready", ready[0], 1);
    check("async_rst_done", done[0], 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_hold_done %0d", i), done[0], 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_done %0d", i), done[0], 0);
      check($sformatf("post_rst_ser %0d", i), ser[0], 1);
      check($sformatf("post_rst_busy %0d", i), busy[0], 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
